// File: rtl/t2mi_from_ts_pkg.sv
// Shared constants and types for the T2-MI-from-TS extractor.
package t2mi_from_ts_pkg;

  localparam logic [7:0]  TS_SYNC        = 8'h47;
  localparam int unsigned TS_PKT_LEN     = 188;
  localparam int unsigned TS_PAYLOAD_LEN = 184;

  // Index of the final byte of a TS packet.
  localparam logic [7:0] TS_LAST_BYTE = 8'(TS_PKT_LEN - 1);
  // Longest adaptation field that still leaves at least one payload byte.
  localparam logic [7:0] AF_LEN_MAX   = 8'(TS_PAYLOAD_LEN - 2);

  typedef enum logic [1:0] {
    AFC_RESERVED     = 2'b00,
    AFC_PAYLOAD_ONLY = 2'b01,
    AFC_AF_ONLY      = 2'b10,
    AFC_AF_PAYLOAD   = 2'b11
  } afc_t;

  typedef enum logic [3:0] {
    ST_WAIT_SYNC = 4'd0,
    ST_HDR       = 4'd1,
    ST_AF_LEN    = 4'd2,
    ST_AF_SKIP   = 4'd3,
    ST_POINTER   = 4'd4,
    ST_PAYLOAD   = 4'd5,
    ST_DISCARD   = 4'd6
  } state_t;

  // Expected continuity counter of the next packet (wraps mod 16).
  function automatic logic [3:0] cc_next(input logic [3:0] cc);
    return cc + 4'd1;
  endfunction

endpackage

// File: rtl/t2mi_from_ts.sv
// T2-MI extractor: parses TS packets on one PID, strips header/AF/pointer,
// marks T2-MI packet starts from the pointer field and checks continuity.
module t2mi_from_ts
  import t2mi_from_ts_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENA_IN,
  input  logic        PSYNC_IN,
  input  logic [7:0]  DATA_IN,
  input  logic [12:0] t2mi_pid,
  output logic [7:0]  DATA_OUT,
  output logic        ENA_OUT,
  output logic        T2MI_START,
  output logic        CC_ERR,
  output logic        SYNC_ERR,
  output logic        LOCKED,
  output logic [3:0]  state_mon
);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tei_q, tei_d;
  logic        pusi_q, pusi_d;
  logic [4:0]  pid_hi_q, pid_hi_d;
  logic        pid_match_q, pid_match_d;
  logic        cc_chk_q, cc_chk_d;
  logic [3:0]  last_cc_q, last_cc_d;
  logic [7:0]  af_rem_q, af_rem_d;
  logic        armed_q, armed_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        locked_q, locked_d;
  logic [7:0]  data_q, data_d;
  logic        ena_q, ena_d;
  logic        start_q, start_d;
  logic        cc_err_q, cc_err_d;
  logic        sync_err_q, sync_err_d;

  afc_t        afc;
  logic [3:0]  cc_in;
  state_t      after_af;

  assign afc      = afc_t'(DATA_IN[5:4]);
  assign cc_in    = DATA_IN[3:0];
  assign after_af = pusi_q ? ST_POINTER : ST_PAYLOAD;

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_WAIT_SYNC;
      cnt_q       <= '0;
      tei_q       <= 1'b0;
      pusi_q      <= 1'b0;
      pid_hi_q    <= '0;
      pid_match_q <= 1'b0;
      cc_chk_q    <= 1'b0;
      last_cc_q   <= '0;
      af_rem_q    <= '0;
      armed_q     <= 1'b0;
      ptr_q       <= '0;
      locked_q    <= 1'b0;
      data_q      <= '0;
      ena_q       <= 1'b0;
      start_q     <= 1'b0;
      cc_err_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tei_q       <= tei_d;
      pusi_q      <= pusi_d;
      pid_hi_q    <= pid_hi_d;
      pid_match_q <= pid_match_d;
      cc_chk_q    <= cc_chk_d;
      last_cc_q   <= last_cc_d;
      af_rem_q    <= af_rem_d;
      armed_q     <= armed_d;
      ptr_q       <= ptr_d;
      locked_q    <= locked_d;
      data_q      <= data_d;
      ena_q       <= ena_d;
      start_q     <= start_d;
      cc_err_q    <= cc_err_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // Packet parser: next state, header fields, CC tracking and forwarding.
  // cc_chk_q is cleared on every unlock so the first accepted packet after
  // an unlock re-seeds the counter instead of being checked against it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tei_d       = tei_q;
    pusi_d      = pusi_q;
    pid_hi_d    = pid_hi_q;
    pid_match_d = pid_match_q;
    cc_chk_d    = cc_chk_q;
    last_cc_d   = last_cc_q;
    af_rem_d    = af_rem_q;
    armed_d     = armed_q;
    ptr_d       = ptr_q;
    locked_d    = locked_q;
    data_d      = data_q;
    ena_d       = 1'b0;
    start_d     = 1'b0;
    cc_err_d    = 1'b0;
    sync_err_d  = 1'b0;

    if (ENA_IN) begin
      if (state_q != ST_WAIT_SYNC && PSYNC_IN) begin
        // Truncated packet: abort and try to restart on the new byte.
        sync_err_d = 1'b1;
        locked_d   = 1'b0;
        cc_chk_d   = 1'b0;
        armed_d    = 1'b0;
        if (DATA_IN == TS_SYNC) begin
          state_d = ST_HDR;
          cnt_d   = 8'd1;
        end else begin
          state_d = ST_WAIT_SYNC;
          cnt_d   = '0;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
        case (state_q)
          ST_WAIT_SYNC: begin
            cnt_d = cnt_q;
            if (PSYNC_IN) begin
              if (DATA_IN == TS_SYNC) begin
                state_d = ST_HDR;
                cnt_d   = 8'd1;
              end else begin
                sync_err_d = 1'b1;
              end
            end
          end
          ST_HDR: begin
            if (cnt_q == 8'd1) begin
              tei_d    = DATA_IN[7];
              pusi_d   = DATA_IN[6];
              pid_hi_d = DATA_IN[4:0];
            end else if (cnt_q == 8'd2) begin
              pid_match_d = ({pid_hi_q, DATA_IN} == t2mi_pid);
            end else begin
              armed_d = 1'b0;
              if (!pid_match_q || tei_q || DATA_IN[7:6] != 2'b00 ||
                  afc == AFC_RESERVED || afc == AFC_AF_ONLY) begin
                state_d = ST_DISCARD;
              end else if (cc_chk_q && cc_in == last_cc_q) begin
                state_d = ST_DISCARD;
              end else begin
                if (cc_chk_q && cc_in != cc_next(last_cc_q)) begin
                  cc_err_d = 1'b1;
                  locked_d = 1'b0;
                  cc_chk_d = 1'b0;
                end else begin
                  cc_chk_d = 1'b1;
                end
                last_cc_d = cc_in;
                state_d   = (afc == AFC_AF_PAYLOAD) ? ST_AF_LEN : after_af;
              end
            end
          end
          ST_AF_LEN: begin
            if (DATA_IN > AF_LEN_MAX) begin
              sync_err_d = 1'b1;
              state_d    = ST_DISCARD;
            end else if (DATA_IN == 8'd0) begin
              state_d = after_af;
            end else begin
              af_rem_d = DATA_IN;
              state_d  = ST_AF_SKIP;
            end
          end
          ST_AF_SKIP: begin
            af_rem_d = af_rem_q - 8'd1;
            if (af_rem_q == 8'd1) state_d = after_af;
          end
          ST_POINTER: begin
            state_d = ST_PAYLOAD;
            if (DATA_IN >= TS_LAST_BYTE - cnt_q) begin
              sync_err_d = 1'b1;
              locked_d   = 1'b0;
              cc_chk_d   = 1'b0;
            end else begin
              armed_d = 1'b1;
              ptr_d   = DATA_IN;
            end
          end
          ST_PAYLOAD: begin
            if (armed_q && ptr_q == 8'd0) begin
              ena_d    = 1'b1;
              start_d  = 1'b1;
              locked_d = 1'b1;
              armed_d  = 1'b0;
            end else begin
              ena_d = locked_q;
              if (armed_q) ptr_d = ptr_q - 8'd1;
            end
          end
          ST_DISCARD: ;
          default: state_d = ST_WAIT_SYNC;
        endcase

        if (state_q != ST_WAIT_SYNC && cnt_q == TS_LAST_BYTE) begin
          state_d = ST_WAIT_SYNC;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end
    end

    if (ena_d) data_d = DATA_IN;
  end

  assign DATA_OUT   = data_q;
  assign ENA_OUT    = ena_q;
  assign T2MI_START = start_q;
  assign CC_ERR     = cc_err_q;
  assign SYNC_ERR   = sync_err_q;
  assign LOCKED     = locked_q;
  assign state_mon  = state_q;

endmodule
